// File: rtl/pwm_audio_pkg.sv
// rtl/pwm_audio_pkg.sv - shared constants and helpers for the PWM audio output
package pwm_audio_pkg;

  localparam int DEFAULT_WIDTH = 8;
  localparam int DEFAULT_DEPTH = 4;

  function automatic int midscale(input int width);
    return 1 << (width - 1);
  endfunction

endpackage

// File: rtl/pwm_audio_out_sample_fifo.sv
// rtl/pwm_audio_out_sample_fifo.sv - synchronous sample FIFO with level count
module sample_fifo
  import pwm_audio_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     push,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full     = (level == LW'(DEPTH));
  assign empty    = (level == '0);
  assign do_push  = push & ~full;
  assign do_pop   = pop & ~empty;
  assign pop_data = mem[rd_ptr];

  // Storage carries no reset; validity is tracked entirely by the pointers and level.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/pwm_audio_out.sv
// rtl/pwm_audio_out.sv - FIFO-fed PWM audio DAC; PWM_SOFTMUTE_EN selects ramped mute
module pwm_audio_out
  import pwm_audio_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  logic                     hwclk,
  input  logic                     reset,
  input  logic [WIDTH-1:0]         sample_in,
  input  logic                     sample_valid,
  output logic                     sample_ready,
  input  logic                     mute,
  output logic                     pwm_out,
  output logic                     period_start,
  output logic                     underflow,
  output logic [$clog2(DEPTH):0]   fifo_level
);

  localparam logic [WIDTH-1:0] MID = WIDTH'(midscale(WIDTH));

  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] duty;
  logic [WIDTH-1:0] next_duty;
  logic [WIDTH-1:0] head;
  logic             load;
  logic             pop;
  logic             full;
  logic             empty;
  logic             empty_at_load;

  assign load         = &cnt;
  assign pop          = load & ~empty;
  assign sample_ready = ~full;

  sample_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo (
    .clk       (hwclk),
    .rst       (reset),
    .push_data (sample_in),
    .push      (sample_valid),
    .pop       (pop),
    .pop_data  (head),
    .full      (full),
    .empty     (empty),
    .level     (fifo_level)
  );

  always_comb begin
    next_duty = duty;
    if (mute) begin
`ifdef PWM_SOFTMUTE_EN
      if (duty > MID)      next_duty = duty - 1'b1;
      else if (duty < MID) next_duty = duty + 1'b1;
`else
      next_duty = MID;
`endif
    end else if (!empty) begin
      next_duty = head;
    end
  end

  // Reset counts as an empty-FIFO start so the first period after release flags underflow.
  always_ff @(posedge hwclk or posedge reset) begin
    if (reset) begin
      cnt           <= '0;
      duty          <= MID;
      pwm_out       <= 1'b0;
      period_start  <= 1'b0;
      underflow     <= 1'b0;
      empty_at_load <= 1'b1;
    end else begin
      cnt          <= cnt + 1'b1;
      pwm_out      <= (cnt < duty);
      period_start <= (cnt == '0);
      underflow    <= (cnt == '0) && empty_at_load;
      if (load) begin
        duty          <= next_duty;
        empty_at_load <= empty;
      end
    end
  end

endmodule

// File: tb/tb_pwm_audio_out.sv
// tb/tb_pwm_audio_out.sv - directed self-checking bench for pwm_audio_out
module tb_pwm_audio_out;

  logic       hwclk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] sample_in = 8'h00;
  logic       sample_valid = 1'b0;
  logic       mute = 1'b0;
  logic       sample_ready;
  logic       pwm_out;
  logic       period_start;
  logic       underflow;
  logic [2:0] fifo_level;

  int n_checks = 0;
  int n_fail = 0;
  logic [7:0] pq[$];

`ifdef PWM_SOFTMUTE_EN
  localparam int M1 = 191, M2 = 190, M3 = 189;
`else
  localparam int M1 = 128, M2 = 128, M3 = 128;
`endif

  pwm_audio_out #(.WIDTH(8), .DEPTH(4)) dut (
    .hwclk        (hwclk),
    .reset        (reset),
    .sample_in    (sample_in),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .mute         (mute),
    .pwm_out      (pwm_out),
    .period_start (period_start),
    .underflow    (underflow),
    .fifo_level   (fifo_level)
  );

  always #5 hwclk = ~hwclk;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic wait_ps(input string tag, input int exp_n);
    int n = 0;
    while (!period_start && n < 600) begin
      @(negedge hwclk);
      n++;
    end
    check(tag, n, exp_n);
  endtask

  // One full period starting on a period_start cycle; queued samples are offered each cycle.
  task automatic measure(input string tag, input int exp_hi, input int exp_uf,
                         input int exp_acc, input int exp_lvl);
    int hi = 0, acc = 0, psn = 0, ufn = 0;
    for (int i = 0; i < 256; i++) begin
      hi  += int'(pwm_out);
      psn += int'(period_start);
      ufn += int'(underflow);
      if (pq.size() != 0 && sample_ready) begin
        sample_valid = 1'b1;
        sample_in    = pq.pop_front();
        acc++;
      end else begin
        sample_valid = 1'b0;
      end
      @(negedge hwclk);
    end
    sample_valid = 1'b0;
    check({tag, "_high"}, hi, exp_hi);
    check({tag, "_ps_pulses"}, psn, 1);
    if (exp_uf >= 0) check({tag, "_uf_pulses"}, ufn, exp_uf);
    check({tag, "_accepted"}, acc, exp_acc);
    check({tag, "_next_ps"}, int'(period_start), 1);
    check({tag, "_level"}, int'(fifo_level), exp_lvl);
  endtask

  initial begin
    repeat (3) @(negedge hwclk);
    check("rst_pwm", int'(pwm_out), 0);
    check("rst_ps", int'(period_start), 0);
    check("rst_uf", int'(underflow), 0);
    check("rst_level", int'(fifo_level), 0);
    check("rst_ready", int'(sample_ready), 1);
    reset = 1'b0;
    wait_ps("first_ps", 1);
    measure("p_first", 128, -1, 0, 0);
    measure("p_idle", 128, 1, 0, 0);

    pq = '{8'h00, 8'h40, 8'hFF};
    measure("p_push3", 128, 1, 3, 2);
    measure("p_00", 0, 0, 0, 1);
    measure("p_40", 64, 0, 0, 0);
    measure("p_ff", 255, 0, 0, 0);
    measure("p_under", 255, 1, 0, 0);

    repeat (254) @(negedge hwclk);
    sample_valid = 1'b1;
    sample_in    = 8'h20;
    @(negedge hwclk);
    sample_valid = 1'b0;
    @(negedge hwclk);
    check("late_ps", int'(period_start), 1);
    check("late_level", int'(fifo_level), 1);
    measure("p_late", 255, 1, 0, 0);
    measure("p_20", 32, 0, 0, 0);

    pq = '{8'hC0, 8'h11, 8'h22, 8'h33};
    measure("p_fill4", 32, 1, 4, 3);
    mute = 1'b1;
    measure("p_c0", 192, 0, 0, 2);
    measure("p_mute1", M1, 0, 0, 1);
    measure("p_mute2", M2, 0, 0, 0);
    mute = 1'b0;
    pq = '{8'h30};
    measure("p_mute3", M3, 0, 1, 0);
    measure("p_unmute", 48, 0, 0, 0);

    pq = '{8'hF0, 8'hF1, 8'hF2, 8'hF3, 8'hF4, 8'hF5};
    measure("p_fillmax", 48, 1, 5, 4);
    check("full_ready", int'(sample_ready), 0);
    measure("p_onepush", 240, 0, 1, 4);
    measure("p_drain", 241, 0, 0, 3);

    repeat (99) @(negedge hwclk);
    check("pre_rst_pwm", int'(pwm_out), 1);
    #2 reset = 1'b1;
    #1;
    check("mid_rst_pwm", int'(pwm_out), 0);
    check("mid_rst_ps", int'(period_start), 0);
    check("mid_rst_uf", int'(underflow), 0);
    check("mid_rst_level", int'(fifo_level), 0);
    check("mid_rst_ready", int'(sample_ready), 1);
    repeat (2) @(negedge hwclk);
    reset = 1'b0;
    wait_ps("post_rst_ps", 1);
    measure("p_rst1", 128, -1, 0, 0);
    measure("p_rst2", 128, 1, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pwm_audio_out.md
PWM_AUDIO_OUT -- requirements
Module: pwm_audio_out

Interface
REQ-001 Parameter WIDTH, default 8: sample and PWM counter width in bits.
REQ-002 Parameter DEPTH, default 4: sample FIFO depth; power of two, minimum 2.
REQ-003 hwclk  input  1  sole clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 sample_in  input  WIDTH  unsigned audio sample from the synthesizer.
REQ-006 sample_valid  input  1  sample_in is valid this cycle.
REQ-007 sample_ready  output  1  block accepts a sample this cycle.
REQ-008 mute  input  1  replace audio with midscale (2^(WIDTH-1)).
REQ-009 pwm_out  output  1  registered PWM audio bit, to the speaker/RC filter pin.
REQ-010 period_start  output  1  one-cycle pulse marking a new PWM period.
REQ-011 underflow  output  1  one-cycle pulse: period started with the FIFO empty.
REQ-012 fifo_level  output  $clog2(DEPTH)+1  number of samples currently stored.

Function
REQ-013 Counter cnt (WIDTH bits) increments every cycle and wraps 2^WIDTH-1 -> 0; period = 2^WIDTH cycles.
REQ-014 sample_ready = (fifo_level != DEPTH); a push occurs when sample_valid && sample_ready; no combinational path from sample_valid to sample_ready.
REQ-015 On the edge where cnt wraps to 0 ("load"): FIFO non-empty -> pop head into duty; empty -> duty holds its value, no pop.
REQ-016 If mute is 1 at load: duty loads midscale instead of the sample; a non-empty FIFO is still popped and the sample discarded.
REQ-017 Push and load on the same edge: both take effect; fifo_level net unchanged; at full, the push is refused because sample_ready is 0.
REQ-018 Push on the same edge as a load with an empty FIFO: the load sees empty (underflow, duty holds); the sample is stored with no bypass.
REQ-019 pwm_out is registered: pwm_out(t+1) = (cnt(t) < duty(t)); duty 0 -> constant 0; duty 2^WIDTH-1 -> high 2^WIDTH-1 of 2^WIDTH cycles.
REQ-020 period_start and underflow are registered pulses, high for exactly the one cycle in which cnt == 1.
REQ-021 sample_in, sample_valid and mute are not synchronised internally; upstream drives them from hwclk.

Reset
REQ-022 While reset is 1: cnt 0, duty midscale, FIFO empty, fifo_level 0, sample_ready 1, pwm_out 0, period_start 0, underflow 0.
REQ-023 Reset asserted mid-period discards FIFO contents and the current period; the first load after release occurs 2^WIDTH cycles after release.

Configuration
REQ-024 Macro PWM_SOFTMUTE_EN defined: while mute is 1, each load moves duty 1 LSB toward midscale (holding at midscale) instead of jumping; the FIFO is still popped.
REQ-025 Macro PWM_SOFTMUTE_EN undefined: mute behaves per REQ-016; no ramp logic is synthesised.
REQ-026 Unmute behaviour is identical in both builds: the next load takes the FIFO sample directly.

Structure
REQ-027 Package pwm_audio_pkg holds the default WIDTH/DEPTH constants and a midscale(width) constant function.
REQ-028 Sub-module sample_fifo: synchronous FIFO (push/pop/full/empty/level, asynchronous active-high reset); pwm_audio_out instantiates it once.

Verification (WIDTH=8, DEPTH=4)
REQ-029 Reset release, no samples -> underflow and period_start pulse every 256 cycles; pwm_out high 128 of 256 cycles.
REQ-030 Push 0x00, 0x40, 0xFF -> successive periods' pwm_out high counts are 0, 64, 255; fifo_level falls 3, 2, 1, 0.
REQ-031 Hold sample_valid=1 from empty -> exactly 4 accepted, sample_ready 0 at level 4; after the load, one push per period is accepted.
REQ-032 sample_valid on the load edge with FIFO empty -> underflow pulse, duty unchanged that period, sample played next period.
REQ-033 Duty 0xC0, then mute=1 with 2 queued samples -> next period high 128 cycles (ramped build: 191, 190, ...); FIFO drains.
REQ-034 Assert reset at cnt=100 with level 3 -> all outputs at REQ-022 values immediately; FIFO empty after release.
